progresive_count: RTL and testbench

PROGRESIVE_COUNT -- requirements
Module: progresive_count

---
 rtl/progresive_count.sv | 118 +++++++++++
 tb/tb_progresive_count.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/progresive_count.sv
// ---------------------------------------------------------------------------
// progresive_count
//
// Purpose:
//   Counts from 0 up to MAX_COUNT once per start request. Each count step
//   takes TICKS clk_out cycles, paced by an internal prescaler. When the
//   terminal value has been held for its full step, the block emits a
//   one-cycle completion pulse and returns to idle. suma keeps showing
//   MAX_COUNT until the next run starts.
//
// Parameters:
//   WIDTH      counter width in bits
//   MAX_COUNT  terminal count value, 1 .. 2^WIDTH-1
//   TICKS      clk_out cycles per count step, >= 1
//
// Ports:
//   clk_out      in   counting clock, all state changes on its rising edge
//   reset        in   synchronous, active-high reset
//   initSignal   in   start request, level-sampled while idle
//   finalSignal  out  registered one-cycle completion pulse
//   busy         out  registered, high while a run is in progress
//   suma         out  registered current count value
// ---------------------------------------------------------------------------
module progresive_count #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 15,
    parameter int TICKS     = 1
) (
    input  logic             clk_out,
    input  logic             reset,
    input  logic             initSignal,
    output logic             finalSignal,
    output logic             busy,
    output logic [WIDTH-1:0] suma
);

    // One extra bit beyond ceil(log2(TICKS)) keeps TICKS=1 at a legal width.
    localparam int PW = $clog2(TICKS) + 1;

    localparam logic [PW-1:0]    PRE_LAST = PW'(TICKS - 1);
    localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] SUM_ONE  = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Declaration values give the same power-up state as reset.
    state_t           state_q = IDLE;
    logic [PW-1:0]    pre_q   = '0;
    logic [WIDTH-1:0] suma_q  = '0;
    logic             final_q = 1'b0;
    logic             busy_q  = 1'b0;

    always_ff @(posedge clk_out) begin
        if (reset) begin
            state_q <= IDLE;
            pre_q   <= '0;
            suma_q  <= '0;
            final_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    final_q <= 1'b0;
                    if (initSignal) begin
                        state_q <= COUNT;
                        suma_q  <= '0;
                        pre_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                COUNT: begin
                    if (pre_q == PRE_LAST) begin
                        pre_q <= '0;
                        // The terminal value must be held for a full step
                        // before completion, so the run spans
                        // (MAX_COUNT+1)*TICKS cycles.
                        if (suma_q >= MAX_VAL) begin
                            state_q <= DONE;
                            suma_q  <= MAX_VAL;
                            final_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            suma_q <= suma_q + SUM_ONE;
                        end
                    end else begin
                        pre_q <= pre_q + PRE_ONE;
                    end
                end

                DONE: begin
                    // Always pass through IDLE, so a held start request
                    // leaves exactly one idle cycle between runs.
                    state_q <= IDLE;
                    final_q <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                    pre_q   <= '0;
                    suma_q  <= '0;
                    final_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign finalSignal = final_q;
    assign busy        = busy_q;
    assign suma        = suma_q;

endmodule

// File: tb/tb_progresive_count.sv
// ---------------------------------------------------------------------------
// tb_progresive_count
//
// Three instances with different pacing (TICKS=1/MAX=15, TICKS=3/MAX=15,
// TICKS=4/MAX=1) share one reset and one start input. A reference model
// describes each run by the number of cycles elapsed since COUNT entry:
// suma = elapsed / TICKS, and completion happens when elapsed reaches
// (MAX_COUNT+1)*TICKS. Directed phases cover reset, single pulse, abort,
// re-trigger during a run and a held start; a random phase follows.
// ---------------------------------------------------------------------------
module tb_progresive_count;

    localparam int N = 3;

    logic       clk_out    = 1'b0;
    logic       reset      = 1'b1;
    logic       initSignal = 1'b0;

    logic       fin0, fin1, fin2;
    logic       bsy0, bsy1, bsy2;
    logic [3:0] sm0, sm1, sm2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, one entry per instance.
    int m_tk  [N];
    int m_mx  [N];
    bit m_run [N];
    bit m_done[N];
    bit m_fin [N];
    int m_el  [N];
    int m_sum [N];

    always #5 clk_out = ~clk_out;

    progresive_count #(.WIDTH(4), .MAX_COUNT(15), .TICKS(1)) u_dut0 (
        .clk_out(clk_out), .reset(reset), .initSignal(initSignal),
        .finalSignal(fin0), .busy(bsy0), .suma(sm0));

    progresive_count #(.WIDTH(4), .MAX_COUNT(15), .TICKS(3)) u_dut1 (
        .clk_out(clk_out), .reset(reset), .initSignal(initSignal),
        .finalSignal(fin1), .busy(bsy1), .suma(sm1));

    progresive_count #(.WIDTH(4), .MAX_COUNT(1), .TICKS(4)) u_dut2 (
        .clk_out(clk_out), .reset(reset), .initSignal(initSignal),
        .finalSignal(fin2), .busy(bsy2), .suma(sm2));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_sum(input int i);
        case (i)
            0:       return {28'd0, sm0};
            1:       return {28'd0, sm1};
            default: return {28'd0, sm2};
        endcase
    endfunction

    function automatic logic [31:0] obs_fin(input int i);
        case (i)
            0:       return {31'd0, fin0};
            1:       return {31'd0, fin1};
            default: return {31'd0, fin2};
        endcase
    endfunction

    function automatic logic [31:0] obs_bsy(input int i);
        case (i)
            0:       return {31'd0, bsy0};
            1:       return {31'd0, bsy1};
            default: return {31'd0, bsy2};
        endcase
    endfunction

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            check_val($sformatf("dut%0d.suma", i),        obs_sum(i), m_sum[i]);
            check_val($sformatf("dut%0d.finalSignal", i), obs_fin(i), {31'd0, m_fin[i]});
            check_val($sformatf("dut%0d.busy", i),        obs_bsy(i), {31'd0, m_run[i]});
        end
    endtask

    // One clock edge: advance the model with the inputs present at the edge,
    // then compare just after the edge.
    task automatic step();
        bit r, s;
        @(posedge clk_out);
        r = reset;
        s = initSignal;
        for (int i = 0; i < N; i++) begin
            if (r) begin
                m_run[i] = 0; m_done[i] = 0; m_fin[i] = 0; m_sum[i] = 0; m_el[i] = 0;
            end else if (m_done[i]) begin
                m_done[i] = 0;
                m_fin[i]  = 0;
            end else if (m_run[i]) begin
                m_el[i]++;
                if (m_el[i] == (m_mx[i] + 1) * m_tk[i]) begin
                    m_run[i]  = 0;
                    m_done[i] = 1;
                    m_fin[i]  = 1;
                    m_sum[i]  = m_mx[i];
                end else begin
                    m_sum[i] = m_el[i] / m_tk[i];
                end
            end else begin
                m_fin[i] = 0;
                if (s) begin
                    m_run[i] = 1;
                    m_el[i]  = 0;
                    m_sum[i] = 0;
                end
            end
        end
        #1;
        compare_all();
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        bit reached;

        m_tk[0] = 1; m_mx[0] = 15;
        m_tk[1] = 3; m_mx[1] = 15;
        m_tk[2] = 4; m_mx[2] = 1;
        for (int i = 0; i < N; i++) begin
            m_run[i] = 0; m_done[i] = 0; m_fin[i] = 0; m_el[i] = 0; m_sum[i] = 0;
        end

        // Power-up values before any clock edge.
        #1;
        compare_all();

        // Reset for two cycles, then idle with no start for ten.
        run_cycles(2);
        reset = 1'b0;
        run_cycles(10);

        // Single start pulse; run long enough for the slowest instance.
        initSignal = 1'b1;
        step();
        initSignal = 1'b0;
        run_cycles(55);

        // Abort the TICKS=1 run at suma=7.
        initSignal = 1'b1;
        step();
        initSignal = 1'b0;
        reached = 0;
        for (int k = 0; k < 40 && !reached; k++) begin
            if (m_run[0] && m_sum[0] == 7) reached = 1;
            else step();
        end
        check_val("reach_suma7", {31'd0, reached}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run_cycles(20);

        // Re-trigger while suma=5: must not restart.
        initSignal = 1'b1;
        step();
        initSignal = 1'b0;
        reached = 0;
        for (int k = 0; k < 40 && !reached; k++) begin
            if (m_run[0] && m_sum[0] == 5) reached = 1;
            else step();
        end
        check_val("reach_suma5", {31'd0, reached}, 32'd1);
        initSignal = 1'b1;
        step();
        initSignal = 1'b0;
        run_cycles(60);

        // Start held high: back-to-back runs with one idle cycle between.
        initSignal = 1'b1;
        run_cycles(150);
        initSignal = 1'b0;
        run_cycles(60);

        // Random starts with rare resets.
        for (int k = 0; k < 1500; k++) begin
            initSignal = ($urandom_range(0, 9) < 3);
            reset      = ($urandom_range(0, 199) == 0);
            step();
        end
        reset      = 1'b0;
        initSignal = 1'b0;
        run_cycles(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
